// File: rtl/if_prefetch_pkg.sv
// Shared constants for the instruction-fetch prefetch stage.
package if_prefetch_pkg;

    localparam int                 INSTR_W = 32;
    localparam logic [INSTR_W-1:0] NOP     = 32'h0;
    localparam int                 PC_STEP = 4;

endpackage

// File: rtl/if_prefetch_if.sv
// Fetch-stage bus: instruction-memory read port, core handshake and redirect.
interface if_prefetch_if #(
    parameter int AW = 32
);
    import if_prefetch_pkg::*;

    logic               i_redirect;
    logic [AW-1:0]      i_redirect_pc;
    logic               o_imem_re;
    logic [AW-1:0]      o_imem_addr;
    logic [INSTR_W-1:0] i_imem_rdata;
    logic               o_instr_valid;
    logic [INSTR_W-1:0] o_instr;
    logic [AW-1:0]      o_instr_pc;
    logic               i_instr_ready;

    // Fetch stage side.
    modport master (
        input  i_redirect, i_redirect_pc, i_imem_rdata, i_instr_ready,
        output o_imem_re, o_imem_addr, o_instr_valid, o_instr, o_instr_pc
    );

    // Core / memory side.
    modport slave (
        output i_redirect, i_redirect_pc, i_imem_rdata, i_instr_ready,
        input  o_imem_re, o_imem_addr, o_instr_valid, o_instr, o_instr_pc
    );

endinterface

// File: rtl/if_prefetch_fifo.sv
// Synchronous FIFO with flush; head word is read straight from registered storage.
module if_prefetch_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 64
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  logic [W-1:0]           data_i,
    input  logic                   pop_i,
    output logic [W-1:0]           data_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   empty_o
);

    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic          do_push, do_pop;

    // Flush has priority over both push and pop.
    assign do_push = push_i & ~flush_i;
    assign do_pop  = pop_i & ~flush_i & (count_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/if_prefetch.sv
// Instruction prefetch: sequential fetch with credit-limited issue, queued
// (pc, instr) pairs to the core, and flush/restart on redirect.
module if_prefetch
    import if_prefetch_pkg::*;
#(
    parameter int            AW       = 32,
    parameter int            DEPTH    = 4,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    if_prefetch_if.master bus
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 2;

    typedef struct packed {
        logic [AW-1:0]      pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    logic [AW-1:0] pc_q, pc_d;
    logic [AW-1:0] issued_pc_q;
    logic          inflight_q;
    logic          credit_ok, issue, push, pop, empty;
    logic [PW:0]   count;
    fetch_entry_t  push_entry, head;

    // Credits cover the word still in flight, so a push can never find the queue full.
    assign credit_ok = (CW'(count) + CW'(inflight_q)) < CW'(DEPTH);
    assign issue     = i_rst_n & credit_ok & ~bus.i_redirect;

    always_comb begin
        pc_d = pc_q;
        if (bus.i_redirect)
            pc_d = bus.i_redirect_pc & ~AW'(3);
        else if (issue)
            pc_d = pc_q + AW'(PC_STEP);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pc_q        <= RESET_PC;
            issued_pc_q <= '0;
            inflight_q  <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            inflight_q <= issue;
            if (issue) issued_pc_q <= pc_q;
        end
    end

    // A response arriving in a redirect cycle belongs to the old stream.
    assign push       = inflight_q & ~bus.i_redirect;
    assign push_entry = fetch_entry_t'{pc: issued_pc_q, instr: bus.i_imem_rdata};
    assign pop        = ~empty & bus.i_instr_ready & ~bus.i_redirect;

    if_prefetch_fifo #(
        .DEPTH (DEPTH),
        .W     ($bits(fetch_entry_t))
    ) u_fifo (
        .clk_i   (i_clk),
        .rst_ni  (i_rst_n),
        .flush_i (bus.i_redirect),
        .push_i  (push),
        .data_i  (push_entry),
        .pop_i   (pop),
        .data_o  (head),
        .count_o (count),
        .empty_o (empty)
    );

    assign bus.o_imem_re     = issue;
    assign bus.o_imem_addr   = pc_q;
    assign bus.o_instr_valid = ~empty;
    assign bus.o_instr       = empty ? NOP : head.instr;
    assign bus.o_instr_pc    = empty ? '0  : head.pc;

endmodule

// File: tb/tb_if_prefetch.sv
// Bench for if_prefetch: directed scenarios plus a randomized run against a
// queue-based model of issue credits, latency and flush behaviour.
module tb_if_prefetch;

    localparam int          DEPTH   = 4;
    localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    if_prefetch_if #(.AW(32)) bus  ();
    if_prefetch_if #(.AW(32)) bus2 ();

    if_prefetch #(.AW(32), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .i_clk (clk), .i_rst_n (rst_n), .bus (bus)
    );

    if_prefetch #(.AW(32), .DEPTH(DEPTH), .RESET_PC(WRAP_PC)) dut_w (
        .i_clk (clk), .i_rst_n (rst_n), .bus (bus2)
    );

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a >> 2) + 32'h100;
    endfunction

    function automatic logic [64:0] exp_out(input logic v, input logic [31:0] pc);
        return v ? {1'b1, pc, memf(pc)} : 65'h0;
    endfunction

    // Memory model: 1-cycle read latency, garbage when not read.
    always @(posedge clk) begin
        bus.i_imem_rdata  <= bus.o_imem_re  ? memf(bus.o_imem_addr)  : $urandom;
        bus2.i_imem_rdata <= bus2.o_imem_re ? memf(bus2.o_imem_addr) : $urandom;
    end

    wire [64:0] out1 = {bus.o_instr_valid, bus.o_instr_pc, bus.o_instr};
    wire [32:0] req1 = {bus.o_imem_re, bus.o_imem_addr};
    wire [64:0] out2 = {bus2.o_instr_valid, bus2.o_instr_pc, bus2.o_instr};
    wire [32:0] req2 = {bus2.o_imem_re, bus2.o_imem_addr};

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.i_redirect    = 1'b0;
        bus.i_redirect_pc = '0;
        bus.i_instr_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.i_instr_ready = 1'b1;
        @(negedge clk);
        #1;
        n_tests++;
        if (req1 !== {1'b0, 32'h0}) begin n_fail++; $display("FAIL reset_req got %h exp %h", req1, {1'b0, 32'h0}); end
        n_tests++;
        if (out1 !== 65'h0) begin n_fail++; $display("FAIL reset_out got %h exp 0", out1); end
        n_tests++;
        if (req2 !== {1'b0, WRAP_PC}) begin n_fail++; $display("FAIL reset_req_w got %h exp %h", req2, {1'b0, WRAP_PC}); end
        n_tests++;
        if (out2 !== 65'h0) begin n_fail++; $display("FAIL reset_out_w got %h exp 0", out2); end
    endtask

    task automatic test_seq();
        do_reset();
        bus.i_instr_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            #1;
            n_tests++;
            if (req1 !== {1'b1, 32'(4 * c)}) begin n_fail++; $display("FAIL seq_req c=%0d got %h exp %h", c, req1, {1'b1, 32'(4 * c)}); end
            n_tests++;
            if (out1 !== exp_out(c >= 2, 32'(4 * (c - 2)))) begin
                n_fail++; $display("FAIL seq_out c=%0d got %h exp %h", c, out1, exp_out(c >= 2, 32'(4 * (c - 2))));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int c = 0; c < 8; c++) begin
            #1;
            n_tests++;
            if (c < 4) begin
                if (req1 !== {1'b1, 32'(4 * c)}) begin n_fail++; $display("FAIL bp_req c=%0d got %h exp %h", c, req1, {1'b1, 32'(4 * c)}); end
            end else begin
                if (bus.o_imem_re !== 1'b0) begin n_fail++; $display("FAIL bp_full_re c=%0d got %b exp 0", c, bus.o_imem_re); end
            end
            n_tests++;
            if (out1 !== exp_out(c >= 2, 32'h0)) begin n_fail++; $display("FAIL bp_out c=%0d got %h exp %h", c, out1, exp_out(c >= 2, 32'h0)); end
            @(negedge clk);
        end
        bus.i_instr_ready = 1'b1;
        #1;
        n_tests++;
        if ({out1, bus.o_imem_re} !== {exp_out(1'b1, 32'h0), 1'b0}) begin
            n_fail++; $display("FAIL bp_pop got %h/%b exp %h/0", out1, bus.o_imem_re, exp_out(1'b1, 32'h0));
        end
        @(negedge clk);
        bus.i_instr_ready = 1'b0;
        #1;
        n_tests++;
        if (req1 !== {1'b1, 32'h10}) begin n_fail++; $display("FAIL bp_refill got %h exp %h", req1, {1'b1, 32'h10}); end
        n_tests++;
        if (out1 !== exp_out(1'b1, 32'h4)) begin n_fail++; $display("FAIL bp_head got %h exp %h", out1, exp_out(1'b1, 32'h4)); end
        @(negedge clk);
        #1;
        n_tests++;
        if (bus.o_imem_re !== 1'b0) begin n_fail++; $display("FAIL bp_refull got %b exp 0", bus.o_imem_re); end
        @(negedge clk);
    endtask

    task automatic test_redirect();
        do_reset();
        repeat (4) @(negedge clk);
        bus.i_redirect    = 1'b1;
        bus.i_redirect_pc = 32'h43;
        #1;
        n_tests++;
        if ({out1, bus.o_imem_re} !== {exp_out(1'b1, 32'h0), 1'b0}) begin
            n_fail++; $display("FAIL rd_cycle got %h/%b exp %h/0", out1, bus.o_imem_re, exp_out(1'b1, 32'h0));
        end
        @(negedge clk);
        bus.i_redirect = 1'b0;
        for (int k = 1; k <= 2; k++) begin
            #1;
            n_tests++;
            if ({out1, req1} !== {65'h0, 1'b1, 32'(32'h3C + 4 * k)}) begin
                n_fail++; $display("FAIL rd_r%0d got %h/%h exp 0/%h", k, out1, req1, {1'b1, 32'(32'h3C + 4 * k)});
            end
            @(negedge clk);
        end
        bus.i_instr_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #1;
            n_tests++;
            if (out1 !== exp_out(1'b1, 32'(32'h40 + 4 * k))) begin
                n_fail++; $display("FAIL rd_drain k=%0d got %h exp %h", k, out1, exp_out(1'b1, 32'(32'h40 + 4 * k)));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_redirect_pop();
        do_reset();
        bus.i_instr_ready = 1'b1;
        repeat (5) @(negedge clk);
        bus.i_redirect    = 1'b1;
        bus.i_redirect_pc = 32'h200;
        #1;
        n_tests++;
        if ({out1, bus.o_imem_re} !== {exp_out(1'b1, 32'hC), 1'b0}) begin
            n_fail++; $display("FAIL rp_cycle got %h/%b exp %h/0", out1, bus.o_imem_re, exp_out(1'b1, 32'hC));
        end
        @(negedge clk);
        bus.i_redirect = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            #1;
            n_tests++;
            if (out1 !== exp_out(k >= 3, 32'(32'h200 + 4 * (k - 3)))) begin
                n_fail++; $display("FAIL rp_out r%0d got %h exp %h", k, out1, exp_out(k >= 3, 32'(32'h200 + 4 * (k - 3))));
            end
            @(negedge clk);
        end
        // Two redirects in a row: only the second target is fetched.
        bus.i_redirect    = 1'b1;
        bus.i_redirect_pc = 32'h300;
        #1;
        n_tests++;
        if (bus.o_imem_re !== 1'b0) begin n_fail++; $display("FAIL b2b_first_re got %b exp 0", bus.o_imem_re); end
        @(negedge clk);
        bus.i_redirect_pc = 32'h406;
        #1;
        n_tests++;
        if ({out1, bus.o_imem_re} !== {65'h0, 1'b0}) begin n_fail++; $display("FAIL b2b_second got %h/%b exp 0/0", out1, bus.o_imem_re); end
        @(negedge clk);
        bus.i_redirect = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            #1;
            if (k <= 2) begin
                n_tests++;
                if (req1 !== {1'b1, 32'(32'h400 + 4 * k)}) begin
                    n_fail++; $display("FAIL b2b_req r%0d got %h exp %h", k, req1, {1'b1, 32'(32'h400 + 4 * k)});
                end
            end
            n_tests++;
            if (out1 !== exp_out(k >= 3, 32'(32'h404 + 4 * (k - 3)))) begin
                n_fail++; $display("FAIL b2b_out r%0d got %h exp %h", k, out1, exp_out(k >= 3, 32'(32'h404 + 4 * (k - 3))));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int c = 0; c < 7; c++) begin
            #1;
            n_tests++;
            if (req2 !== {1'b1, WRAP_PC + 32'(4 * c)}) begin
                n_fail++; $display("FAIL wrap_req c=%0d got %h exp %h", c, req2, {1'b1, WRAP_PC + 32'(4 * c)});
            end
            n_tests++;
            if (out2 !== exp_out(c >= 2, WRAP_PC + 32'(4 * (c - 2)))) begin
                n_fail++; $display("FAIL wrap_out c=%0d got %h exp %h", c, out2, exp_out(c >= 2, WRAP_PC + 32'(4 * (c - 2))));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        bus.i_instr_ready = 1'b1;
        repeat (6) @(negedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({req1, out1} !== {1'b0, 32'h0, 65'h0}) begin n_fail++; $display("FAIL arst_out got %h/%h exp 0", req1, out1); end
        n_tests++;
        if ({req2, out2} !== {1'b0, WRAP_PC, 65'h0}) begin n_fail++; $display("FAIL arst_out_w got %h/%h exp %h/0", req2, out2, {1'b0, WRAP_PC}); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            n_tests++;
            if ({req1, out1} !== {1'b1, 32'(4 * c), exp_out(c >= 2, 32'(4 * (c - 2)))}) begin
                n_fail++; $display("FAIL arst_restart c=%0d got %h/%h exp %h/%h", c, req1, out1,
                                   {1'b1, 32'(4 * c)}, exp_out(c >= 2, 32'(4 * (c - 2))));
            end
            @(negedge clk);
        end
    endtask

    typedef struct {
        logic [31:0] pc;
        int          avail;
    } exp_ent_t;

    task automatic test_random();
        exp_ent_t    q[$];
        logic [31:0] exp_issue = 32'h0;
        logic [31:0] head_pc;
        logic        exp_re, exp_v, rdy, redir;
        int          phase;
        do_reset();
        for (int c = 0; c < 800; c++) begin
            phase = (c / 64) % 3;
            rdy   = (phase == 0) ? 1'b1 : (phase == 1) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 3) == 0);
            redir = ($urandom_range(0, 19) == 0);
            bus.i_instr_ready = rdy;
            bus.i_redirect    = redir;
            bus.i_redirect_pc = $urandom;
            #1;
            exp_re  = (q.size() < DEPTH) && !redir;
            exp_v   = (q.size() > 0) && (q[0].avail <= c);
            head_pc = exp_v ? q[0].pc : 32'h0;
            n_tests++;
            if (bus.o_imem_re !== exp_re) begin n_fail++; $display("FAIL rnd_re c=%0d got %b exp %b", c, bus.o_imem_re, exp_re); end
            if (exp_re) begin
                n_tests++;
                if (bus.o_imem_addr !== exp_issue) begin n_fail++; $display("FAIL rnd_addr c=%0d got %h exp %h", c, bus.o_imem_addr, exp_issue); end
            end
            n_tests++;
            if (out1 !== exp_out(exp_v, head_pc)) begin n_fail++; $display("FAIL rnd_out c=%0d got %h exp %h", c, out1, exp_out(exp_v, head_pc)); end
            if (redir) begin
                q.delete();
                exp_issue = bus.i_redirect_pc & 32'hFFFF_FFFC;
            end else begin
                if (exp_v && rdy) void'(q.pop_front());
                if (exp_re) begin
                    q.push_back('{pc: exp_issue, avail: c + 2});
                    exp_issue = exp_issue + 32'd4;
                end
            end
            @(negedge clk);
            if (n_fail > 50) break;
        end
        bus.i_redirect = 1'b0;
    endtask

    initial begin
        bus.i_redirect     = 1'b0;
        bus.i_redirect_pc  = '0;
        bus.i_instr_ready  = 1'b0;
        bus2.i_redirect    = 1'b0;
        bus2.i_redirect_pc = '0;
        bus2.i_instr_ready = 1'b1;
        test_reset();
        test_seq();
        test_backpressure();
        test_redirect();
        test_redirect_pop();
        test_wrap();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
        $fatal(1);
    end

endmodule
